// File: rtl/vga_pkg.sv
// Shared VGA-domain types and defaults for frame-synchronous blocks.
package vga_pkg;

    localparam int COORD_W_DFLT     = 10;
    localparam int NUM_SPRITES_DFLT = 5;

    typedef logic [COORD_W_DFLT-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } sprite_pos_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2,
        DONE    = 2'd3
    } commit_state_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Frame-start detector: one-cycle pulse on the falling edge of the active-low vsync.
module vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic fs
);

    logic vsync_q;

    // Previous vsync sample; resets high so a low vsync at release counts as a frame start.
    always_ff @(posedge clk) begin
        if (!rst) vsync_q <= 1'b1;
        else      vsync_q <= vsync;
    end

    assign fs = vsync_q & ~vsync;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: CPU writes a shadow bank, which is copied into
// the renderer-visible active bank one slot per cycle at the start of vsync.
module sprite_pos_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DFLT,
    parameter int COORD_W     = COORD_W_DFLT,
    parameter int FCNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               wr_en,
    input  logic [2:0]         wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    output logic               wr_ready,
    input  logic               commit_req,
    output logic               commit_pending,
    output logic               commit_ack,
    output logic [COORD_W-1:0] pos_x [NUM_SPRITES],
    output logic [COORD_W-1:0] pos_y [NUM_SPRITES],
    output logic [FCNT_W-1:0]  frame_count,
    output logic               wr_err
);

    commit_state_t      state;
    logic               requeue;
    logic               rdy_q;
    logic [2:0]         idx;
    logic               fs;
    logic               idx_ok;
    logic               wr_ok;
    logic [COORD_W-1:0] sh_x [NUM_SPRITES];
    logic [COORD_W-1:0] sh_y [NUM_SPRITES];

    vsync_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .fs    (fs)
    );

    // Shadow bank is locked only while it is being copied out.
    assign wr_ready       = rdy_q & (state != COPY);
    assign idx_ok         = 32'(wr_idx) < 32'(NUM_SPRITES);
    assign wr_ok          = wr_en & wr_ready & idx_ok;
    assign commit_ack     = (state == DONE);
    assign commit_pending = (state == PENDING) | (state == COPY) |
                            ((state == DONE) & requeue);

    // Shadow bank: CPU-side writes, bit-exact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_ok && wr_idx == 3'(i)) begin
                    sh_x[i] <= wr_x;
                    sh_y[i] <= wr_y;
                end
            end
        end
    end

    // Sticky out-of-range write flag; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)                               wr_err <= 1'b0;
        else if (wr_en && wr_ready && !idx_ok)  wr_err <= 1'b1;
    end

    // Frame counter runs regardless of commit activity.
    always_ff @(posedge clk) begin
        if (!rst)    frame_count <= '0;
        else if (fs) frame_count <= frame_count + 1'b1;
    end

    // Commit sequencer; a request arriving mid-commit is parked in requeue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            requeue <= 1'b0;
            idx     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (commit_req) state <= PENDING;
                end
                PENDING: begin
                    if (fs) begin
                        state <= COPY;
                        idx   <= '0;
                    end
                end
                COPY: begin
                    if (commit_req) requeue <= 1'b1;
                    if (idx == 3'(NUM_SPRITES - 1)) state <= DONE;
                    else                            idx   <= idx + 3'd1;
                end
                default: begin
                    state   <= (requeue || commit_req) ? PENDING : IDLE;
                    requeue <= 1'b0;
                end
            endcase
        end
    end

    // Active bank: updated one slot per COPY cycle, otherwise held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else if (state == COPY) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (idx == 3'(i)) begin
                    pos_x[i] <= sh_x[i];
                    pos_y[i] <= sh_y[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Bench for sprite_pos_ctrl: directed scenarios plus random traffic against a
// timeline model (commit = snapshot of shadow at frame start, visible N+1 later).
module tb_sprite_pos_ctrl;

    localparam int N  = 5;
    localparam int CW = 10;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vsync = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_idx = '0;
    logic [CW-1:0] wr_x = '0;
    logic [CW-1:0] wr_y = '0;
    logic          commit_req = 1'b0;
    logic          wr_ready, commit_pending, commit_ack, wr_err;
    logic [CW-1:0] pos_x [N];
    logic [CW-1:0] pos_y [N];
    logic [FW-1:0] frame_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_pos_ctrl #(.NUM_SPRITES(N), .COORD_W(CW), .FCNT_W(FW)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_ready(wr_ready), .commit_req(commit_req),
        .commit_pending(commit_pending), .commit_ack(commit_ack),
        .pos_x(pos_x), .pos_y(pos_y), .frame_count(frame_count), .wr_err(wr_err)
    );

    // Reference model state
    logic [CW-1:0] m_sx [N], m_sy [N], m_ax [N], m_ay [N], sn_x [N], sn_y [N];
    logic [FW-1:0] m_fc;
    bit m_err, m_pend, m_again, m_rdy, m_vprev;
    int m_busy;   // cycles since the consuming frame start (0 = no commit running)

    function automatic bit m_copying();
        return (m_busy >= 1) && (m_busy <= N);
    endfunction
    function automatic bit m_ack();
        return m_busy == N + 1;
    endfunction
    function automatic bit m_wr_ready();
        return m_rdy && !m_copying();
    endfunction
    function automatic bit m_cpend();
        return m_pend || m_copying() || (m_ack() && m_again);
    endfunction

    // Advance one clock with current inputs, updating the model alongside.
    task automatic cyc();
        bit fs, rdy;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_sx[i] = '0; m_sy[i] = '0; m_ax[i] = '0; m_ay[i] = '0;
            end
            m_fc = '0; m_err = 0; m_pend = 0; m_again = 0; m_busy = 0;
            m_rdy = 0; m_vprev = 1;
        end else begin
            fs = m_vprev && !vsync;
            m_vprev = vsync;
            rdy = m_wr_ready();
            if (wr_en && rdy) begin
                if (wr_idx < N) begin
                    m_sx[wr_idx] = wr_x;
                    m_sy[wr_idx] = wr_y;
                end else m_err = 1;
            end
            if (fs) m_fc = m_fc + 1'b1;
            if (m_ack()) begin
                m_busy  = 0;
                m_pend  = m_again || commit_req;
                m_again = 0;
            end else if (m_copying()) begin
                if (commit_req) m_again = 1;
                m_busy++;
                if (m_busy == N + 1) begin
                    m_ax = sn_x;
                    m_ay = sn_y;
                end
            end else if (m_pend) begin
                if (fs) begin
                    m_busy = 1;
                    sn_x = m_sx;
                    sn_y = m_sy;
                    m_pend = 0;
                end
            end else if (commit_req) m_pend = 1;
            m_rdy = 1;
        end
        #1;
    endtask

    // Request a commit, supply a frame start, return cycles from fs cycle to ack.
    task automatic commit_now(output int n);
        commit_req = 1; cyc(); commit_req = 0;
        vsync = 0; n = 0;
        do begin
            cyc(); vsync = 1; n++;
        end while (!commit_ack && n < 20);
    endtask

    task automatic test_reset();
        bit seen = 0;
        rst = 0; vsync = 1;
        cyc(); cyc();
        checks++;
        if (wr_ready !== 1'b0 || commit_pending !== 1'b0 || commit_ack !== 1'b0 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy=%b pend=%b ack=%b err=%b want 0000",
                     wr_ready, commit_pending, commit_ack, wr_err);
        end
        checks++;
        if (frame_count !== 0) begin
            errors++; $display("FAIL reset_fcnt: got %0d want 0", frame_count);
        end
        rst = 1; cyc();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", wr_ready);
        end
        repeat (3) begin
            vsync = 0; cyc(); if (commit_ack) seen = 1;
            vsync = 1; cyc(); if (commit_ack) seen = 1;
            cyc(); if (commit_ack) seen = 1;
        end
        checks++;
        if (frame_count !== 3) begin
            errors++; $display("FAIL idle_frames: got %0d want 3", frame_count);
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL idle_ack: got 1 want 0");
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pos_x[i] !== 0 || pos_y[i] !== 0) begin
                errors++; $display("FAIL idle_pos[%0d]: got (%0d,%0d) want (0,0)", i, pos_x[i], pos_y[i]);
            end
        end
    endtask

    task automatic test_basic_commit();
        int n = 0, zc = 0;
        bit seen = 0;
        wr_en = 1; wr_idx = 2; wr_x = 100; wr_y = 300; cyc(); wr_en = 0;
        commit_req = 1; cyc(); commit_req = 0;
        repeat (50) begin cyc(); if (commit_ack) seen = 1; end
        checks++;
        if (pos_x[2] !== 0 || seen || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold: x2=%0d ack_seen=%b pend=%b want 0,0,1", pos_x[2], seen, commit_pending);
        end
        vsync = 0;
        do begin
            cyc(); vsync = 1; n++;
            if (!wr_ready) zc++;
        end while (!commit_ack && n < 20);
        checks++;
        if (n !== N + 1) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", n, N + 1);
        end
        checks++;
        if (zc !== N) begin
            errors++; $display("FAIL basic_lockout: got %0d want %0d", zc, N);
        end
        checks++;
        if (pos_x[2] !== 100 || pos_y[2] !== 300) begin
            errors++; $display("FAIL basic_pos: got (%0d,%0d) want (100,300)", pos_x[2], pos_y[2]);
        end
        cyc();
        checks++;
        if (commit_ack !== 1'b0 || commit_pending !== 1'b0) begin
            errors++; $display("FAIL basic_ack_width: ack=%b pend=%b want 0,0", commit_ack, commit_pending);
        end
    endtask

    task automatic test_write_lockout();
        int n = 0, zc = 0;
        commit_req = 1; cyc(); commit_req = 0;
        vsync = 0; cyc(); vsync = 1;
        wr_en = 1; wr_idx = 0; wr_x = 7; wr_y = 9;
        while (!commit_ack && n < 20) begin
            if (!wr_ready) zc++;
            cyc(); n++;
        end
        checks++;
        if (zc !== N || wr_ready !== 1'b1) begin
            errors++; $display("FAIL lock_cycles: got %0d rdy=%b want %0d rdy=1", zc, wr_ready, N);
        end
        cyc(); wr_en = 0;
        checks++;
        if (pos_x[0] !== 0 || pos_y[0] !== 0) begin
            errors++; $display("FAIL lock_old: got (%0d,%0d) want (0,0)", pos_x[0], pos_y[0]);
        end
        commit_now(n);
        checks++;
        if (pos_x[0] !== 7 || pos_y[0] !== 9 || pos_x[2] !== 100) begin
            errors++; $display("FAIL lock_new: got (%0d,%0d) x2=%0d want (7,9) 100", pos_x[0], pos_y[0], pos_x[2]);
        end
        cyc();
    endtask

    task automatic test_requeue();
        int n = 0;
        bit seen = 0;
        commit_req = 1; cyc(); commit_req = 0;
        vsync = 0; cyc(); vsync = 1;
        cyc();
        commit_req = 1; cyc(); commit_req = 0;
        while (!commit_ack && n < 20) begin cyc(); n++; end
        checks++;
        if (commit_ack !== 1'b1 || commit_pending !== 1'b1) begin
            errors++; $display("FAIL requeue_done: ack=%b pend=%b want 1,1", commit_ack, commit_pending);
        end
        repeat (10) begin cyc(); if (commit_ack) seen = 1; end
        checks++;
        if (seen || commit_pending !== 1'b1) begin
            errors++; $display("FAIL requeue_wait: ack_seen=%b pend=%b want 0,1", seen, commit_pending);
        end
        vsync = 0; n = 0;
        do begin cyc(); vsync = 1; n++; end while (!commit_ack && n < 20);
        checks++;
        if (n !== N + 1) begin
            errors++; $display("FAIL requeue_second: got %0d want %0d", n, N + 1);
        end
        cyc();
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++; $display("FAIL requeue_clear: got %b want 0", commit_pending);
        end
    endtask

    task automatic test_same_cycle();
        int n = 0;
        bit seen = 0;
        commit_req = 1; vsync = 0; cyc(); commit_req = 0; vsync = 1;
        repeat (10) begin cyc(); if (commit_ack || !wr_ready) seen = 1; end
        checks++;
        if (seen || commit_pending !== 1'b1) begin
            errors++; $display("FAIL same_cycle_skip: copy_seen=%b pend=%b want 0,1", seen, commit_pending);
        end
        vsync = 0;
        do begin cyc(); vsync = 1; n++; end while (!commit_ack && n < 20);
        checks++;
        if (n !== N + 1) begin
            errors++; $display("FAIL same_cycle_next: got %0d want %0d", n, N + 1);
        end
        cyc();
    endtask

    task automatic test_bad_idx();
        int n;
        wr_en = 1; wr_idx = 1; wr_x = 11; wr_y = 22; cyc();
        wr_idx = 6; wr_x = 555; wr_y = 555; cyc();
        wr_en = 0;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL bad_idx_flag: got %b want 1", wr_err);
        end
        repeat (5) cyc();
        commit_now(n);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL bad_idx_sticky: got %b want 1", wr_err);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pos_x[i] === 555 || pos_x[i] !== m_ax[i] || pos_y[i] !== m_ay[i]) begin
                errors++;
                $display("FAIL bad_idx_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", i, pos_x[i], pos_y[i], m_ax[i], m_ay[i]);
            end
        end
        checks++;
        if (pos_x[1] !== 11 || pos_y[1] !== 22) begin
            errors++; $display("FAIL bad_idx_slot1: got (%0d,%0d) want (11,22)", pos_x[1], pos_y[1]);
        end
        cyc();
    endtask

    task automatic test_reset_mid_copy();
        bit seen = 0;
        commit_req = 1; cyc(); commit_req = 0;
        vsync = 0; cyc(); vsync = 1;
        cyc(); cyc();
        rst = 0; cyc(); rst = 1;
        checks++;
        if (commit_ack !== 1'b0 || commit_pending !== 1'b0 || frame_count !== 0 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: ack=%b pend=%b fcnt=%0d err=%b want 0,0,0,0",
                     commit_ack, commit_pending, frame_count, wr_err);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pos_x[i] !== 0 || pos_y[i] !== 0) begin
                errors++; $display("FAIL midreset_pos[%0d]: got (%0d,%0d) want (0,0)", i, pos_x[i], pos_y[i]);
            end
        end
        repeat (10) begin cyc(); if (commit_ack || commit_pending) seen = 1; end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midreset_idle: commit activity after reset");
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 399) != 0);
            vsync      = ($urandom_range(0, 11) != 0);
            commit_req = ($urandom_range(0, 7) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_idx     = 3'($urandom_range(0, 7));
            wr_x       = CW'($urandom);
            wr_y       = CW'($urandom);
            cyc();
            checks++;
            if (wr_ready !== m_wr_ready() || commit_ack !== m_ack() || commit_pending !== m_cpend() ||
                frame_count !== m_fc || wr_err !== m_err) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_ctrl@%0d: rdy=%b ack=%b pend=%b fc=%0d err=%b want %b %b %b %0d %b",
                             c, wr_ready, commit_ack, commit_pending, frame_count, wr_err,
                             m_wr_ready(), m_ack(), m_cpend(), m_fc, m_err);
            end
            if (!m_copying()) begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (pos_x[i] !== m_ax[i] || pos_y[i] !== m_ay[i]) begin
                        errors++; bad++;
                        if (bad < 10)
                            $display("FAIL rand_pos@%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                                     c, i, pos_x[i], pos_y[i], m_ax[i], m_ay[i]);
                    end
                end
            end
        end
        rst = 1; wr_en = 0; commit_req = 0; vsync = 1;
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_write_lockout();
        test_requeue();
        test_same_cycle();
        test_bad_idx();
        test_reset_mid_copy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
